// File: rtl/ip_uart_rx_inst.sv
// 8N1 UART receiver on the Z80 I/O bus: oversampled start/stop validation,
// 16-entry receive FIFO, data port at io_address and status/control at io_address+1.
module ip_uart_rx_inst #(
    parameter int unsigned clk_freq        = 74250000,
    parameter int unsigned uart_freq       = 115200,
    parameter logic [7:0]  io_address      = 8'h10,
    parameter int unsigned fifo_depth_log2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_address,
    input  logic       bus_ioreq,
    input  logic       bus_write,
    input  logic       bus_valid,
    output logic       bus_ready,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_en,
    input  logic       uart_rx
);

    localparam int unsigned DIV   = clk_freq / uart_freq;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned PTR_W = fifo_depth_log2;
    localparam int unsigned CNT_F = fifo_depth_log2 + 1;
    localparam int unsigned DEPTH = 1 << fifo_depth_log2;

    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
    localparam logic [7:0]       STAT_ADDR = io_address + 8'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic             sync_meta, sync_rx, sync_dly;
    logic             tick, push, frame_err_set;

    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_F-1:0] fifo_count;
    logic             not_empty, full, framing_err, overrun;

    logic             rd_data_hit, rd_stat_hit, wr_stat_hit;
    logic             pop, push_ok, clear_flags, flush;
    logic [7:0]       status;
    logic             wdata_unused;

    assign bus_ready    = 1'b1;
    assign wdata_unused = ^bus_wdata[7:2];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_rx   <= 1'b1;
            sync_dly  <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
        end else begin
            sync_meta <= uart_rx;
            sync_rx   <= sync_meta;
            sync_dly  <= sync_rx;
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            rx_byte   <= rx_byte_nxt;
        end
    end

    assign tick = (baud_cnt == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        rx_byte_nxt   = rx_byte;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (!sync_rx && sync_dly) begin
                    state_nxt    = START;
                    baud_cnt_nxt = HALF_M1;
                end
            end
            START: begin
                if (!tick) begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end else if (!sync_rx) begin
                    state_nxt    = DATA;
                    baud_cnt_nxt = DIV_M1;
                    bit_idx_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end else begin
                    rx_byte_nxt[bit_idx] = sync_rx;
                    baud_cnt_nxt         = DIV_M1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (!tick) begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end else begin
                    push          = sync_rx;
                    frame_err_set = !sync_rx;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_data_hit = bus_valid && bus_ioreq && !bus_write && (bus_address == io_address);
    assign rd_stat_hit = bus_valid && bus_ioreq && !bus_write && (bus_address == STAT_ADDR);
    assign wr_stat_hit = bus_valid && bus_ioreq &&  bus_write && (bus_address == STAT_ADDR);
    assign clear_flags = wr_stat_hit && bus_wdata[0];
    assign flush       = wr_stat_hit && bus_wdata[1];

    assign not_empty = (fifo_count != '0);
    assign full      = (fifo_count == CNT_F'(DEPTH));
    assign pop       = rd_data_hit && not_empty;
    // A pop in the same cycle frees the slot before the push lands.
    assign push_ok   = push && (!full || pop);
    assign status    = {4'b0000, overrun, framing_err, full, not_empty};

    // NOTE: the FIFO storage is not reset; the reset pointers and count make stale words unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_F'(1);
                2'b01:   fifo_count <= fifo_count - CNT_F'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            framing_err  <= 1'b0;
            overrun      <= 1'b0;
            bus_rdata_en <= 1'b0;
            bus_rdata    <= 8'h00;
        end else begin
            if (frame_err_set)                 framing_err <= 1'b1;
            else if (clear_flags)              framing_err <= 1'b0;
            if (push && full && !pop)          overrun <= 1'b1;
            else if (clear_flags)              overrun <= 1'b0;
            bus_rdata_en <= rd_data_hit || rd_stat_hit;
            if (pop)              bus_rdata <= fifo_mem[rd_ptr];
            else if (rd_stat_hit) bus_rdata <= status;
            else                  bus_rdata <= 8'h00;
        end
    end

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Directed bench for ip_uart_rx_inst. The baud rate is raised to give DIV=20 (HALF=10)
// so all scenarios fit in a short run; glitch length is scaled to stay below HALF.
module tb_ip_uart_rx_inst;

    localparam int DIV = 20;            // 74250000 / 3600000, truncated
    localparam logic [7:0] DATA_PORT = 8'h10;
    localparam logic [7:0] STAT_PORT = 8'h11;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_address;
    logic       bus_ioreq;
    logic       bus_write;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic       uart_rx;

    int n_tests = 0;
    int n_fail  = 0;

    ip_uart_rx_inst #(
        .clk_freq(74250000),
        .uart_freq(3600000),
        .io_address(8'h10),
        .fifo_depth_log2(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_address(bus_address),
        .bus_ioreq(bus_ioreq),
        .bus_write(bus_write),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_rdata_en(bus_rdata_en),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data,
                            output logic en1, output logic en2);
        bus_address = addr;
        bus_write   = 1'b0;
        bus_ioreq   = 1'b1;
        bus_valid   = 1'b1;
        @(posedge clk); #1;
        bus_valid = 1'b0;
        bus_ioreq = 1'b0;
        data = bus_rdata;
        en1  = bus_rdata_en;
        @(posedge clk); #1;
        en2 = bus_rdata_en;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic e1, e2;
        bus_read(addr, d, e1, e2);
        check({tag, " data"}, d, exp);
        check({tag, " en"}, {e1, e2}, 2'b10);
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [7:0] data);
        bus_address = addr;
        bus_wdata   = data;
        bus_write   = 1'b1;
        bus_ioreq   = 1'b1;
        bus_valid   = 1'b1;
        @(posedge clk); #1;
        bus_valid = 1'b0;
        bus_ioreq = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (DIV) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic e1, e2;
        reset = 1'b1;
        uart_rx = 1'b1;
        bus_address = 8'h00;
        bus_ioreq = 1'b0;
        bus_write = 1'b0;
        bus_valid = 1'b0;
        bus_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset ready", bus_ready, 1'b1);
        check("reset rdata", bus_rdata, 8'h00);
        check("reset rdata_en", bus_rdata_en, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        read_check("reset status", STAT_PORT, 8'h00);
        read_check("empty data read", DATA_PORT, 8'h00);
        bus_read(8'h12, d, e1, e2);
        check("non-hit rdata_en", {e1, e2}, 2'b00);
        check("non-hit rdata", d, 8'h00);

        // Basic reception
        send_frame(8'h55, 1'b1);
        read_check("0x55 status", STAT_PORT, 8'h01);
        read_check("0x55 data", DATA_PORT, 8'h55);
        read_check("0x55 status after", STAT_PORT, 8'h00);

        // Framing error: byte discarded, flag set until cleared
        send_frame(8'hA3, 1'b0);
        read_check("ferr status", STAT_PORT, 8'h04);
        read_check("ferr data", DATA_PORT, 8'h00);
        bus_wr(STAT_PORT, 8'h01);
        read_check("ferr cleared", STAT_PORT, 8'h00);

        // Short low glitch must not start a frame
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        read_check("glitch status", STAT_PORT, 8'h00);
        send_frame(8'h3C, 1'b1);
        read_check("post-glitch data", DATA_PORT, 8'h3C);

        // Overrun: 17 bytes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        read_check("overrun status", STAT_PORT, 8'h0B);
        for (int i = 0; i < 16; i++) read_check($sformatf("drain %0d", i), DATA_PORT, 8'(i));
        read_check("drained status", STAT_PORT, 8'h08);

        // Reset pulse mid-DATA of a 0xFF frame
        uart_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midframe reset ready", bus_ready, 1'b1);
        check("midframe reset rdata", bus_rdata, 8'h00);
        check("midframe reset rdata_en", bus_rdata_en, 1'b0);
        repeat (8 * DIV) @(posedge clk);
        #1;
        read_check("midframe reset status", STAT_PORT, 8'h00);
        send_frame(8'h81, 1'b1);
        read_check("post-reset data", DATA_PORT, 8'h81);

        // Full FIFO with a data read landing on the stop-bit push cycle
        for (int i = 0; i < 16; i++) send_frame(8'hA0 + 8'(i), 1'b1);
        read_check("full status", STAT_PORT, 8'h03);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                // Push happens at the 193rd edge after the start bit (3 + HALF + 9*DIV).
                repeat (192) @(posedge clk);
                #1;
                read_check("pop on push", DATA_PORT, 8'hA0);
            end
        join
        read_check("pop on push status", STAT_PORT, 8'h03);
        for (int i = 1; i < 16; i++)
            read_check($sformatf("full drain %0d", i), DATA_PORT, 8'hA0 + 8'(i));
        read_check("late byte", DATA_PORT, 8'h5A);
        read_check("full drained status", STAT_PORT, 8'h00);

        // Flush discards stored bytes
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        read_check("pre-flush status", STAT_PORT, 8'h01);
        bus_wr(STAT_PORT, 8'h02);
        read_check("flush status", STAT_PORT, 8'h00);
        read_check("flush data", DATA_PORT, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
